// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, default latencies and width helper for the hazard scoreboard
package hazard_pkg;

  localparam int AW_DEF       = 4;
  localparam int LOAD_LAT_DEF = 2;
  localparam int ALU_LAT_DEF  = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  localparam int LAT_MAX_DEF = (LOAD_LAT_DEF > ALU_LAT_DEF) ? LOAD_LAT_DEF : ALU_LAT_DEF;
  localparam int LAT_W_DEF   = clog2(LAT_MAX_DEF + 1);

  typedef logic [AW_DEF-1:0]    reg_addr_t;
  typedef logic [LAT_W_DEF-1:0] lat_cnt_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// rtl/hazard_sb_entry.sv - one scoreboard entry: latency countdown with load priority over decrement
module hazard_sb_entry #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic [CW-1:0] o_cnt,
  output logic          o_busy
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-write scoreboard driving ID-stage stall controls
// Optional EX/MEM bypass awareness and id_fwd port: HAZARD_SCOREBOARD_FORWARDING_EN
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int ALU_LAT  = ALU_LAT_DEF,
  parameter int R0_ZERO  = 1,
  parameter int PERF_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_kill,
  input  logic [NUM_SRC*AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic [AW-1:0]         id_dst_addr,
  input  logic                  id_dst_we,
  input  logic                  id_is_load,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic [PERF_W-1:0]     stall_cycles
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
  ,
  output logic [NUM_SRC-1:0]    id_fwd
`endif
);

  localparam int NREG = 2 ** AW;
  localparam int MAXL = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
  localparam int CW   = clog2(MAXL + 1);
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
  localparam logic [CW-1:0] THR = CW'(1);
`else
  localparam logic [CW-1:0] THR = '0;
`endif

  generate
    if (LOAD_LAT < 1 || ALU_LAT < 1) begin : g_bad_lat
      $error("hazard_scoreboard: LOAD_LAT and ALU_LAT must be >= 1");
    end
  endgenerate

  logic [CW-1:0]      w_cnt [NREG];
  logic [NREG-1:0]    w_busy;
  logic [NREG-1:0]    w_load;
  logic [CW-1:0]      w_load_val;
  logic [AW-1:0]      w_src_addr [NUM_SRC];
  logic [CW-1:0]      w_src_cnt [NUM_SRC];
  logic [NUM_SRC-1:0] w_src_live;
  logic [NUM_SRC-1:0] w_raw;
  logic               w_dst_live;
  logic               w_waw;
  logic               w_stall;
  logic               w_issue;
  logic [PERF_W-1:0]  r_stall_cycles;

  // Register 0 is masked at the compare so it can never raise a hazard or be loaded.
  assign w_dst_live = id_dst_we & ~((R0_ZERO != 0) && (id_dst_addr == '0));
  assign w_waw      = w_dst_live & w_busy[id_dst_addr];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_src_addr[gi] = id_src_addr[gi*AW +: AW];
      assign w_src_cnt[gi]  = w_cnt[w_src_addr[gi]];
      assign w_src_live[gi] = id_src_used[gi] & ~((R0_ZERO != 0) && (w_src_addr[gi] == '0));
      assign w_raw[gi]      = w_src_live[gi] & (w_src_cnt[gi] > THR);
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
      assign id_fwd[gi]     = w_src_live[gi] & (w_src_cnt[gi] == CW'(1));
`endif
    end
  endgenerate

  assign w_stall    = id_valid & ~id_kill & ((|w_raw) | w_waw);
  assign w_issue    = id_valid & ~id_kill & ~w_stall;
  assign w_load_val = id_is_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);

  genvar gr;
  generate
    for (gr = 0; gr < NREG; gr++) begin : g_entry
      assign w_load[gr] = w_issue & w_dst_live & (id_dst_addr == AW'(gr));
      hazard_sb_entry #(
        .CW (CW)
      ) u_entry (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load[gr]),
        .i_load_val (w_load_val),
        .o_cnt      (w_cnt[gr]),
        .o_busy     (w_busy[gr])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall        = w_stall;
  assign pc_write     = ~w_stall;
  assign ifid_write   = ~w_stall;
  assign idex_bubble  = w_stall;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized checks of hazard_scoreboard against a ready-time model
module tb_hazard_scoreboard;

  localparam int AW = 4;
  localparam int NS = 2;
  localparam int LL = 2;
  localparam int AL = 1;
  localparam int PW = 4;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
  localparam int THR = 1;
`else
  localparam int THR = 0;
`endif
  localparam int LU_STALLS  = LL - THR;
  localparam int ALU_STALLS = AL - THR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0;
  logic             id_valid = 1'b0;
  logic             id_kill = 1'b0;
  logic [NS*AW-1:0] id_src_addr = '0;
  logic [NS-1:0]    id_src_used = '0;
  logic [AW-1:0]    id_dst_addr = '0;
  logic             id_dst_we = 1'b0;
  logic             id_is_load = 1'b0;
  logic             stall, pc_write, ifid_write, idex_bubble;
  logic [PW-1:0]    stall_cycles;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
  logic [NS-1:0]    id_fwd;
`endif

  hazard_scoreboard #(
    .AW(AW), .NUM_SRC(NS), .LOAD_LAT(LL), .ALU_LAT(AL), .R0_ZERO(1), .PERF_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used), .id_dst_addr(id_dst_addr),
    .id_dst_we(id_dst_we), .id_is_load(id_is_load), .stall(stall), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .stall_cycles(stall_cycles)
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    , .id_fwd(id_fwd)
`endif
  );

  // Model: each register remembers the cycle number at which its result becomes readable.
  int now = 0;
  int ready [16];
  int m_stalls = 0;
  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  function automatic int remaining(input int r);
    return (ready[r] > now) ? ready[r] - now : 0;
  endfunction

  function automatic bit exp_stall();
    bit haz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int a = int'(id_src_addr[i*AW +: AW]);
      if (id_src_used[i] && a != 0 && remaining(a) > THR) haz = 1'b1;
    end
    if (id_dst_we && id_dst_addr != 0 && remaining(int'(id_dst_addr)) > 0) haz = 1'b1;
    return id_valid && !id_kill && haz;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 16; r++) ready[r] = 0;
      now = 0;
      m_stalls = 0;
    end else begin
      bit s;
      s = exp_stall();
      if (s && m_stalls < (2 ** PW) - 1) m_stalls++;
      if (id_valid && !id_kill && !s && id_dst_we && id_dst_addr != 0)
        ready[id_dst_addr] = now + 1 + (id_is_load ? LL : AL);
      now++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit es;
      es = exp_stall();
      check("stall", int'(stall), int'(es));
      check("pc_write", int'(pc_write), int'(!es));
      check("ifid_write", int'(ifid_write), int'(!es));
      check("idex_bubble", int'(idex_bubble), int'(es));
      check("stall_cycles", int'(stall_cycles), m_stalls);
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
      for (int i = 0; i < NS; i++) begin
        int a = int'(id_src_addr[i*AW +: AW]);
        check("id_fwd", int'(id_fwd[i]), int'(id_src_used[i] && a != 0 && remaining(a) == 1));
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit k, input int s0, input int s1, input int used,
                       input int d, input bit we, input bit ld);
    id_valid    = v;
    id_kill     = k;
    id_src_addr = {AW'(s1), AW'(s0)};
    id_src_used = NS'(used);
    id_dst_addr = AW'(d);
    id_dst_we   = we;
    id_is_load  = ld;
  endtask

  task automatic count_stalls(output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      step();
    end
    step();
  endtask

  int n;

  initial begin
    // Reset held with a valid instruction present
    rst = 1'b0;
    drive(1, 0, 3, 4, 3, 3, 1, 1);
    repeat (3) step();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_stall", int'(stall), 0);
    check("reset_pc_write", int'(pc_write), 1);
    check("reset_stall_cycles", int'(stall_cycles), 0);
    step();
    rst = 1'b1;

    // Load-use on r3
    drive(1, 0, 0, 0, 0, 3, 1, 1);
    step();
    drive(1, 0, 3, 0, 1, 0, 0, 0);
    count_stalls(n);
    check("load_use_stalls", n, LU_STALLS);
    check("load_use_stall_cycles", int'(stall_cycles), LU_STALLS);

    // ALU write r5 then read r5
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    step();
    drive(1, 0, 0, 5, 2, 0, 0, 0);
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    @(negedge clk);
    check("alu_fwd", int'(id_fwd[1]), 1);
    step();
`else
    count_stalls(n);
    check("alu_use_stalls", n, ALU_STALLS);
`endif

    // Killed instruction while r3 busy, then r9 must still be free
    drive(1, 0, 0, 0, 0, 3, 1, 1);
    step();
    drive(1, 1, 3, 0, 1, 9, 1, 0);
    @(negedge clk);
    check("kill_no_stall", int'(stall), 0);
    step();
    drive(1, 0, 9, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("kill_no_entry", int'(stall), 0);
    step();

    // Unused operand on a busy register
    drive(1, 0, 0, 0, 0, 3, 1, 1);
    step();
    drive(1, 0, 3, 3, 0, 0, 0, 0);
    @(negedge clk);
    check("unused_no_stall", int'(stall), 0);
    step();

    // WAW on r7
    drive(1, 0, 0, 0, 0, 7, 1, 1);
    step();
    drive(1, 0, 0, 0, 0, 7, 1, 0);
    count_stalls(n);
    check("waw_stalls", n, LL);

    // r0 never busy
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    step();
    drive(1, 0, 0, 0, 3, 0, 1, 0);
    @(negedge clk);
    check("r0_no_stall", int'(stall), 0);
    step();

    // Reset in the first cycle of a load-use stall
    drive(1, 0, 0, 0, 0, 3, 1, 1);
    step();
    drive(1, 0, 3, 0, 1, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_before", int'(stall), 1);
    step();
    @(negedge clk);
    check("midreset_after", int'(stall), 0);
    check("midreset_count", int'(stall_cycles), 0);
    step();
    rst = 1'b1;

    // Saturation of the 4-bit stall counter
    for (int i = 0; i < 20 / LU_STALLS; i++) begin
      drive(1, 0, 0, 0, 0, 6, 1, 1);
      step();
      drive(1, 0, 6, 0, 1, 0, 0, 0);
      count_stalls(n);
    end
    @(negedge clk);
    check("stall_cycles_sat", int'(stall_cycles), 15);
    step();

    // Randomized traffic over a narrow address range to provoke frequent hazards
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
      step();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
